// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_gen clock-enable generator.
package clk_div_pkg;

  typedef enum logic {
    CLK_DIV_PULSE  = 1'b0,
    CLK_DIV_SQUARE = 1'b1
  } clk_div_mode_e;

  localparam int unsigned CLK_DIV_MIN = 2;

  // Divisors below the minimum would leave no room for a boundary cycle.
  function automatic int unsigned clk_div_clamp(input int unsigned div);
    return (div < CLK_DIV_MIN) ? CLK_DIV_MIN : div;
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Control/status bundle between a clk_div_gen and the block that programs it.
interface clk_div_gen_if #(
  parameter int W = 8
);
  logic         en;
  logic         mode;
  logic [W-1:0] div;
  logic         div_load;
  logic         tick;
  logic         clk_div;
  logic         div_pend;

  modport master (
    output en, mode, div, div_load,
    input  tick, clk_div, div_pend
  );

  modport slave (
    input  en, mode, div, div_load,
    output tick, clk_div, div_pend
  );
endinterface

// File: rtl/clk_div_shadow.sv
// Pending divisor/mode register with transfer to the active set at period boundaries.
// Mode storage exists only when CLK_DIV_GEN_SQUARE_EN is defined.
module clk_div_shadow
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DIV_DEFAULT = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          last,
  input  logic          div_load,
  input  logic [W-1:0]  div,
`ifdef CLK_DIV_GEN_SQUARE_EN
  input  clk_div_mode_e mode,
  output clk_div_mode_e act_mode,
`endif
  output logic [W-1:0]  act_div,
  output logic          div_pend
);
  logic [W-1:0] act_div_q, act_div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic [W-1:0] cap_div;
  logic         pend_q, pend_d;
  logic         boundary, xfer;
`ifdef CLK_DIV_GEN_SQUARE_EN
  clk_div_mode_e act_mode_q, act_mode_d;
  clk_div_mode_e pend_mode_q, pend_mode_d;
`endif

  assign boundary = en & last;
  // While held there is no period in progress to protect, so transfer at once.
  assign xfer     = pend_q & (boundary | ~en);
  assign cap_div  = W'(clk_div_clamp(32'(div)));

  always_comb begin
    act_div_d  = act_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
`ifdef CLK_DIV_GEN_SQUARE_EN
    act_mode_d  = act_mode_q;
    pend_mode_d = pend_mode_q;
`endif
    if (xfer) begin
      act_div_d = pend_div_q;
      pend_d    = 1'b0;
`ifdef CLK_DIV_GEN_SQUARE_EN
      act_mode_d = pend_mode_q;
`endif
    end
    if (div_load) begin
      if (boundary) begin
        act_div_d = cap_div;
`ifdef CLK_DIV_GEN_SQUARE_EN
        act_mode_d = mode;
`endif
      end else begin
        pend_div_d = cap_div;
        pend_d     = 1'b1;
`ifdef CLK_DIV_GEN_SQUARE_EN
        pend_mode_d = mode;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_div_q  <= W'(DIV_DEFAULT);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
`ifdef CLK_DIV_GEN_SQUARE_EN
      act_mode_q  <= CLK_DIV_PULSE;
      pend_mode_q <= CLK_DIV_PULSE;
`endif
    end else begin
      act_div_q  <= act_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
`ifdef CLK_DIV_GEN_SQUARE_EN
      act_mode_q  <= act_mode_d;
      pend_mode_q <= pend_mode_d;
`endif
    end
  end

  assign act_div  = act_div_q;
  assign div_pend = pend_q;
`ifdef CLK_DIV_GEN_SQUARE_EN
  assign act_mode = act_mode_q;
`endif

endmodule

// File: rtl/clk_div_gen.sv
// Runtime-programmable clock-enable generator: single-cycle tick once per divisor period.
// Square-wave output on clk_div is compiled in only when CLK_DIV_GEN_SQUARE_EN is defined.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int W           = 8,
  parameter int DIV_DEFAULT = 5
) (
  input  logic         clk,
  input  logic         reset,
  clk_div_gen_if.slave bus
);
  if (W < 2 || W > 31) begin : g_chk_w
    $error("clk_div_gen: W must be in 2..31");
  end
  if (DIV_DEFAULT < CLK_DIV_MIN || DIV_DEFAULT > (2 ** W) - 1) begin : g_chk_div
    $error("clk_div_gen: DIV_DEFAULT must be in 2..2^W-1");
  end

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] nxt;
  logic [W-1:0] act_div;
  logic         last;
  logic         tick_q, tick_d;
  logic         div_pend;

  // >= rather than == so a divisor shrunk during hold below the held count still wraps.
  assign last = (cnt_q >= act_div - W'(1));
  assign nxt  = last ? '0 : cnt_q + W'(1);

`ifdef CLK_DIV_GEN_SQUARE_EN
  clk_div_mode_e act_mode;
  logic          clk_div_q, clk_div_d;

  function automatic logic [W:0] ceil_half(input logic [W-1:0] d);
    logic [W:0] s;
    s = {1'b0, d} + {{W{1'b0}}, 1'b1};
    return s >> 1;
  endfunction

  clk_div_shadow #(.W(W), .DIV_DEFAULT(DIV_DEFAULT)) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .last     (last),
    .div_load (bus.div_load),
    .div      (bus.div),
    .mode     (clk_div_mode_e'(bus.mode)),
    .act_mode (act_mode),
    .act_div  (act_div),
    .div_pend (div_pend)
  );

  always_comb begin
    clk_div_d = clk_div_q;
    if (bus.en) begin
      clk_div_d = (act_mode == CLK_DIV_SQUARE) ? ({1'b0, nxt} >= ceil_half(act_div)) : last;
    end else if (act_mode == CLK_DIV_PULSE) begin
      clk_div_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_div_q <= 1'b0;
    end else begin
      clk_div_q <= clk_div_d;
    end
  end

  assign bus.clk_div = clk_div_q;
`else
  clk_div_shadow #(.W(W), .DIV_DEFAULT(DIV_DEFAULT)) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .last     (last),
    .div_load (bus.div_load),
    .div      (bus.div),
    .act_div  (act_div),
    .div_pend (div_pend)
  );

  assign bus.clk_div = tick_q;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (bus.en) begin
      cnt_d  = nxt;
      tick_d = last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.div_pend = div_pend;

endmodule
